// File: rtl/csa_stream_accumulator_if.sv
// rtl/csa_stream_accumulator_if.sv - operand/result stream bundle for the carry-save stream accumulator
interface csa_stream_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int N_OPS = 9
);
    localparam int OUT_W = WIDTH + $clog2(N_OPS);
    localparam int CNT_W = $clog2(N_OPS + 1);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sum;
    logic [CNT_W-1:0] op_count;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, op_count
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, op_count
    );
endinterface

// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - sequential multi-operand adder folding a stream into a carry-save pair
module csa_stream_accumulator #(
    parameter int WIDTH  = 16,
    parameter int N_OPS  = 9,
    parameter int SIGNED = 0
) (
    input  logic clk,
    input  logic rst_n,
    csa_stream_accumulator_if.slave bus
);
    localparam int OUT_W = WIDTH + $clog2(N_OPS);
    localparam int CNT_W = $clog2(N_OPS + 1);
    localparam int EXT_W = OUT_W - WIDTH;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] s_vec;
    logic [OUT_W-1:0] c_vec;
    logic [OUT_W-1:0] sum_q;
    logic [OUT_W-1:0] x;
    logic [OUT_W-1:0] maj;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic             accept;
    logic             last_op;

    always_comb begin
        x = {{EXT_W{1'b0}}, bus.in_data};
        if (SIGNED != 0) begin
            x = {{EXT_W{bus.in_data[WIDTH-1]}}, bus.in_data};
        end
    end

    // One 3:2 compressor layer; the carry MSB shifted out is a multiple of 2^OUT_W and drops exactly.
    assign maj     = (s_vec & c_vec) | (s_vec & x) | (c_vec & x);
    assign accept  = bus.in_valid && (state == ACCUM);
    assign last_op = (cnt == CNT_W'(N_OPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            s_vec       <= '0;
            c_vec       <= '0;
            cnt         <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            state       <= ACCUM;
            s_vec       <= '0;
            c_vec       <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s_vec <= s_vec ^ c_vec ^ x;
                        c_vec <= maj << 1;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_op) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    sum_q       <= s_vec + c_vec;
                    out_valid_q <= 1'b1;
                    s_vec       <= '0;
                    c_vec       <= '0;
                    cnt         <= '0;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.op_count  = cnt;
endmodule
